// File: rtl/alu.sv
// 16-bit datapath ALU: combinational result and flags, plus a one-cycle
// registered copy of result/zero for status and debug.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_operation,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  typedef enum logic [2:0] {
    OP_MOVE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_NOP  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  alu_op_e        w_op;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_s1;
  logic           w_s2;

  assign w_op   = alu_op_e'(alu_operation);
  // Bit WIDTH of the zero-extended difference is the unsigned borrow.
  assign w_sum  = {1'b0, in1} + {1'b0, in2};
  assign w_diff = {1'b0, in1} - {1'b0, in2};
  assign w_s1   = in1[WIDTH-1];
  assign w_s2   = in2[WIDTH-1];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result        = in1;
    carry_flag    = 1'b0;
    overflow_flag = 1'b0;
    case (w_op)
      OP_MOVE: result = in2;
      OP_ADD: begin
        result        = w_sum[WIDTH-1:0];
        carry_flag    = w_sum[WIDTH];
        overflow_flag = (w_s1 == w_s2) && (w_sum[WIDTH-1] != w_s1);
      end
      OP_SUB: begin
        result        = w_diff[WIDTH-1:0];
        carry_flag    = w_diff[WIDTH];
        overflow_flag = (w_s1 != w_s2) && (w_diff[WIDTH-1] != w_s1);
      end
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_NOT:  result = ~in2;
      OP_NOP:  result = in1;
      OP_RSVD: result = in1;
      default: result = in1;
    endcase
  end

  assign zero_flag = (result == '0);

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result;
      zero_q   <= zero_flag;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: table of combinational cases plus
// hand-written sequences for the registered path and asynchronous reset.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_operation;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] result;
  logic        zero_flag;
  logic        carry_flag;
  logic        overflow_flag;
  logic [15:0] result_q;
  logic        zero_q;

  int n_compared   = 0;
  int n_mismatched = 0;

  alu #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_operation (alu_operation),
    .in1           (in1),
    .in2           (in2),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .result_q      (result_q),
    .zero_q        (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_result;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    vecs[0]  = '{3'b000, 16'd10,    16'd6,    16'd6,    1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 16'd10,    16'd6,    16'd16,   1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 16'd10,    16'd6,    16'd4,    1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 16'd10,    16'd6,    16'd2,    1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 16'd10,    16'd6,    16'd14,   1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 16'd10,    16'd6,    16'hFFF9, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 16'd10,    16'd6,    16'd10,   1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 16'd10,    16'd6,    16'd10,   1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 16'd10,    16'd10,   16'd0,    1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 16'hFFFF,  16'd1,    16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'b001, 16'h7FFF,  16'd1,    16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'b010, 16'h0000,  16'd1,    16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b010, 16'h8000,  16'd1,    16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'b000, 16'h1234,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'b101, 16'h1234,  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b110, 16'h0000,  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b011, 16'hFFFF,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset held: registered outputs cleared, combinational path live.
    rst_n = 1'b0;
    alu_operation = 3'b001;
    in1 = 16'd10;
    in2 = 16'd6;
    repeat (2) @(posedge clk);
    #1;
    check("reset result_q", result_q, 16'h0000);
    check("reset zero_q", {15'b0, zero_q}, 16'h0000);
    check("reset comb result", result, 16'd16);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      alu_operation = vecs[i].op;
      in1 = vecs[i].a;
      in2 = vecs[i].b;
      #1;
      check($sformatf("v%0d result", i),   result,                 vecs[i].exp_result);
      check($sformatf("v%0d zero", i),     {15'b0, zero_flag},     {15'b0, vecs[i].exp_zero});
      check($sformatf("v%0d carry", i),    {15'b0, carry_flag},    {15'b0, vecs[i].exp_carry});
      check($sformatf("v%0d overflow", i), {15'b0, overflow_flag}, {15'b0, vecs[i].exp_ovf});
    end

    // Registered path: establish a known captured value of 0 first.
    @(negedge clk);
    alu_operation = 3'b010; in1 = 16'd10; in2 = 16'd10;
    @(posedge clk); #1;
    check("seq0 result_q", result_q, 16'h0000);
    check("seq0 zero_q", {15'b0, zero_q}, 16'h0001);

    @(negedge clk);
    alu_operation = 3'b001; in1 = 16'd10; in2 = 16'd6;
    #1;
    check("seq1 result_q before edge", result_q, 16'h0000);
    @(posedge clk); #1;
    check("seq1 result_q", result_q, 16'd16);
    check("seq1 zero_q", {15'b0, zero_q}, 16'h0000);

    @(negedge clk);
    alu_operation = 3'b010; in1 = 16'd10; in2 = 16'd10;
    #1;
    check("seq2 zero_q before edge", {15'b0, zero_q}, 16'h0000);
    @(posedge clk); #1;
    check("seq2 zero_q", {15'b0, zero_q}, 16'h0001);
    check("seq2 result_q", result_q, 16'h0000);

    // Asynchronous reset between edges with result_q = 16.
    @(negedge clk);
    alu_operation = 3'b001; in1 = 16'd10; in2 = 16'd6;
    @(posedge clk); #1;
    check("pre-reset result_q", result_q, 16'd16);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset result_q", result_q, 16'h0000);
    check("async reset zero_q", {15'b0, zero_q}, 16'h0000);
    check("reset comb result live", result, 16'd16);
    @(posedge clk); #1;
    check("reset held over edge", result_q, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release no capture yet", result_q, 16'h0000);
    @(posedge clk); #1;
    check("capture after release", result_q, 16'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
